// File: rtl/msk_rnd_source_if.sv
// Seed-load and randomness-consumption signals of msk_rnd_source.
// The slave modport is the source itself; master is the seeding/consuming side.
interface msk_rnd_source_if #(
  parameter int NRND = 8
);
  logic [31:0]     seed_in;
  logic            seed_valid;
  logic            seed_ready;
  logic            rnd_en;
  logic [NRND-1:0] rnd_out;
  logic            rnd_valid;
  logic            seed_err;

  modport master (
    output seed_in,
    output seed_valid,
    output rnd_en,
    input  seed_ready,
    input  rnd_out,
    input  rnd_valid,
    input  seed_err
  );

  modport slave (
    input  seed_in,
    input  seed_valid,
    input  rnd_en,
    output seed_ready,
    output rnd_out,
    output rnd_valid,
    output seed_err
  );
endinterface

// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for masked gadgets: seeded 64-bit Fibonacci LFSR
// with a two-word seed load, optional warm-up and a valid/enable output.
module msk_rnd_source #(
  parameter int NRND = 8,
  parameter int WARM = 128
) (
  input logic              clk,
  input logic              rst_n,
  msk_rnd_source_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WARMUP,
    RUN
  } state_e;

  localparam logic [15:0] WARM_CNT = 16'(WARM);

  state_e          state_q, state_d;
  logic [63:0]     s_q, s_d;
  logic [31:0]     s_hi_q, s_hi_d;
  logic [15:0]     warm_cnt_q, warm_cnt_d;
  logic            seed_err_q, seed_err_d;

  logic [NRND-1:0] fb_bits;
  logic [63:0]     s_adv;
  logic [63:0]     seed_full;
  logic            seed_ready;
  logic            seed_accept;

  // NRND chained LFSR steps; fb_bits[0] is the first step's feedback.
  always_comb begin
    s_adv   = s_q;
    fb_bits = '0;
    for (int i = 0; i < NRND; i++) begin
      fb_bits[i] = s_adv[63] ^ s_adv[62] ^ s_adv[60] ^ s_adv[59];
      s_adv      = {s_adv[62:0], fb_bits[i]};
    end
  end

  assign seed_ready  = (state_q != WARMUP);
  assign seed_accept = bus.seed_valid & seed_ready;
  assign seed_full   = {s_hi_q, bus.seed_in};

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    s_hi_d     = s_hi_q;
    warm_cnt_d = warm_cnt_q;
    seed_err_d = seed_err_q;
    unique case (state_q)
      IDLE: begin
        if (seed_accept) begin
          s_hi_d  = bus.seed_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (seed_accept) begin
          // An all-zero state would lock the LFSR, so substitute 1 and flag it.
          if (seed_full == 64'h0) begin
            s_d        = 64'h1;
            seed_err_d = 1'b1;
          end else begin
            s_d        = seed_full;
            seed_err_d = 1'b0;
          end
          if (WARM == 0) begin
            state_d = RUN;
          end else begin
            state_d    = WARMUP;
            warm_cnt_d = WARM_CNT;
          end
        end
      end
      WARMUP: begin
        s_d        = s_adv;
        warm_cnt_d = warm_cnt_q - 16'd1;
        if (warm_cnt_q == 16'd1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.rnd_en) begin
          s_d = s_adv;
        end
        if (seed_accept) begin
          s_hi_d  = bus.seed_in;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= 64'h0;
      s_hi_q     <= 32'h0;
      warm_cnt_q <= 16'h0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      s_hi_q     <= s_hi_d;
      warm_cnt_q <= warm_cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign bus.seed_ready = seed_ready;
  assign bus.rnd_valid  = (state_q == RUN);
  assign bus.rnd_out    = (state_q == RUN) ? fb_bits : '0;
  assign bus.seed_err   = seed_err_q;

endmodule

// File: doc/msk_rnd_source.md
Name: msk_rnd_source

Overview:
- Fresh-randomness source for masked gadgets (AND2 GHPC and similar). Each consumed cycle it supplies NRND uniform bits.
- Built as a seeded 64-bit Fibonacci LFSR with a seed-load handshake, a warm-up phase, and a valid/enable consumption interface.
- Sits directly upstream of the gadgets' rnd inputs. The pipeline controller gates rnd_en with its own advance signal so every gadget cycle sees fresh bits.

Parameters:
- NRND, 8, random bits delivered per consumed cycle (1..32).
- WARM, 128, warm-up cycles after seeding before output is valid (0..65535; 0 = none).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seed_in  input  32  seed word.
- seed_valid  input  1  seed word present.
- seed_ready  output  1  seed word can be accepted.
- rnd_en  input  1  consumer takes rnd_out this cycle.
- rnd_out  output  NRND  random bits to gadgets.
- rnd_valid  output  1  rnd_out is valid.
- seed_err  output  1  last loaded seed was all-zero (sticky).

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0: fsm=IDLE, LFSR state s[63:0]=0, half-seed register=0, warm counter=0, seed_err=0.
- Outputs during reset: seed_ready=1, rnd_valid=0, rnd_out=0.
- Reset mid-load, mid-warm-up or mid-run discards everything. A fresh two-word seed is required afterwards.
- LFSR step: fb = s[63]^s[62]^s[60]^s[59]; s_next = {s[62:0], fb}.
- One cycle advance = NRND chained steps, unrolled combinationally.
- rnd_out[i] = fb of step i (i=0 first) computed from the current registered s. It is combinational look-ahead and forced to 0 when fsm != RUN.
- FSM states: IDLE, LOAD, WARMUP, RUN.
- seed_ready = 1 in IDLE, LOAD and RUN; 0 in WARMUP. A word is accepted on seed_valid & seed_ready.
- IDLE: first accepted word is stored as s_hi, then go to LOAD.
- LOAD: second accepted word gives s = {s_hi, word}.
  - If that value is all-zero: s = 64'h1 and seed_err = 1; otherwise seed_err = 0.
  - Go to WARMUP with counter = WARM, or straight to RUN if WARM = 0.
  - LOAD with no word accepted: hold indefinitely.
- WARMUP: advance s by one cycle advance every cycle and decrement the counter. When the counter reaches 1, next state is RUN.
  - The second word accepted at edge t gives RUN from edge t+WARM.
  - seed_valid is ignored in WARMUP.
- RUN: rnd_valid = 1 (combinational from fsm).
  - Advance s when rnd_en = 1; hold s when rnd_en = 0.
  - rnd_en while rnd_valid = 0 is ignored, with no state change.
- Reseed from RUN: an accepted word moves to LOAD (stored as s_hi) and rnd_valid falls next cycle.
  - A simultaneous rnd_en in that same cycle still advances s; the advance is discarded by the later load.
- seed_err changes only on completion of a load, or on reset.
- Word order: first word → s[63:32], second word → s[31:0].
- Randomness uniformity and security are outside this block's properties: it is assumed-uniform for fullverif, and the seed is provided by the TRNG.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → next sample shows rnd_valid=0, rnd_out=0, seed_ready=1, seed_err=0. Load with WARM=0 and no stall; state matches a fresh load.
- Basic load, NRND=1, WARM=0: words 0x80000000 then 0x00000000 → RUN at next edge with rnd_out=1. After one rnd_en cycle, s=64'h1 and rnd_out=0. Following advance: s=64'h2, rnd_out=0.
- Zero seed, NRND=1, WARM=0: words 0 and 0 → seed_err=1, s=64'h1, rnd_valid=1. A later load of 0x80000000, 0 clears seed_err to 0.
- Warm-up timing, WARM=4, NRND=8: second word accepted at edge t → rnd_valid=0 and seed_ready=0 through t+3, rnd_valid=1 at t+4. s matches the reference model after 32 steps; seed_valid held high during warm-up is not accepted.
- Stall and unroll, NRND=8, WARM=0: random seed, random rnd_en pattern over 1000 cycles → rnd_out sequence equals the reference model's serial bitstream chunked 8 bits per consumed cycle, with no advance on rnd_en=0 cycles.
- Reseed in RUN: seed_valid pulse with rnd_en=1 in the same cycle → LOAD, rnd_valid=0 next cycle. After the second word, output equals fresh-seed model output (the advance is discarded).
